// File: rtl/ipulse_seq_pkg.sv
// Shared types and helpers for the current-pulse sequencer.
package ipulse_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int NUM_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      HIGH  = 2'd2,
      LOW   = 2'd3
   } state_e;

   // A train needs a non-empty high phase and a non-empty low phase.
   function automatic logic cfg_legal(input logic [31:0] tw, input logic [31:0] tp);
      return (tw != 32'd0) && (tp > tw);
   endfunction

endpackage

// File: rtl/ipulse_seq_if.sv
// Control/config/status bundle between the controller and the pulse sequencer.
interface ipulse_seq_if
   import ipulse_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int NUM_W = NUM_W_DEF
);
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] cfg_td;
   logic [CNT_W-1:0] cfg_tw;
   logic [CNT_W-1:0] cfg_tp;
   logic [NUM_W-1:0] cfg_num;
   logic             cfg_sink;
   logic             pout;
   logic             sink_sel;
   logic             busy;
   logic             done;
   logic             cfg_err;
   logic [NUM_W-1:0] pulse_idx;

   modport master (
      output start, abort, cfg_td, cfg_tw, cfg_tp, cfg_num, cfg_sink,
      input  pout, sink_sel, busy, done, cfg_err, pulse_idx
   );

   modport slave (
      input  start, abort, cfg_td, cfg_tw, cfg_tp, cfg_num, cfg_sink,
      output pout, sink_sel, busy, done, cfg_err, pulse_idx
   );
endinterface

// File: rtl/ipulse_seq_timer.sv
// Loadable down-counter shared by the delay, high and low phases.
module ipulse_timer
   import ipulse_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] val_i,
   output logic             zero_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Load wins over decrement; the count parks at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = val_i;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/ipulse_seq.sv
// Current-pulse sequencer: delay, then tw-high / (tp-tw)-low pulses, finite or continuous.
module ipulse_seq
   import ipulse_pkg::*;
#(
   parameter int   CNT_W = CNT_W_DEF,
   parameter int   NUM_W = NUM_W_DEF,
   parameter logic B0    = 1'b0,
   parameter logic B1    = 1'b1
) (
   input logic         clk,
   input logic         rstb,
   ipulse_seq_if.slave bus
);
   state_e           state_q;
   logic [CNT_W-1:0] tw_q, tp_q;
   logic [NUM_W-1:0] num_q, idx_q, idx_d;
   logic             pout_q, sink_q, busy_q, done_q, err_q;
   logic             tmr_load, tmr_en, tmr_zero;
   logic [CNT_W-1:0] tmr_val;
   logic             req, legal, last_pulse;

   assign req        = bus.start && !bus.abort;
   assign legal      = cfg_legal(32'(bus.cfg_tw), 32'(bus.cfg_tp));
   assign idx_d      = idx_q + NUM_W'(1);
   assign last_pulse = (num_q != '0) && (idx_d == num_q);
   assign tmr_en     = (state_q != IDLE);

   // Timer is loaded with (phase length - 1) on every phase entry.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         IDLE: begin
            if (req && legal) begin
               tmr_load = 1'b1;
               tmr_val  = (bus.cfg_td == '0) ? bus.cfg_tw - CNT_W'(1)
                                             : bus.cfg_td - CNT_W'(1);
            end
         end
         DELAY: begin
            if (!bus.abort && tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = tw_q - CNT_W'(1);
            end
         end
         HIGH: begin
            if (!bus.abort && tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = tp_q - tw_q - CNT_W'(1);
            end
         end
         LOW: begin
            if (!bus.abort && tmr_zero && !last_pulse) begin
               tmr_load = 1'b1;
               tmr_val  = tw_q - CNT_W'(1);
            end
         end
         default: begin
            tmr_load = 1'b0;
            tmr_val  = '0;
         end
      endcase
   end

   ipulse_timer #(.CNT_W(CNT_W)) u_timer (
      .clk    (clk),
      .rstb   (rstb),
      .load_i (tmr_load),
      .en_i   (tmr_en),
      .val_i  (tmr_val),
      .zero_o (tmr_zero)
   );

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= IDLE;
         tw_q    <= '0;
         tp_q    <= '0;
         num_q   <= '0;
         idx_q   <= '0;
         pout_q  <= B0;
         sink_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req && legal) begin
                  tw_q    <= bus.cfg_tw;
                  tp_q    <= bus.cfg_tp;
                  num_q   <= bus.cfg_num;
                  sink_q  <= bus.cfg_sink;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= (bus.cfg_td == '0) ? HIGH : DELAY;
                  pout_q  <= (bus.cfg_td == '0) ? B1 : B0;
               end else if (req) begin
                  err_q <= 1'b1;
               end
            end
            DELAY, HIGH, LOW: begin
               if (bus.abort) begin
                  state_q <= IDLE;
                  pout_q  <= B0;
                  busy_q  <= 1'b0;
               end else if (tmr_zero) begin
                  case (state_q)
                     DELAY: begin
                        state_q <= HIGH;
                        pout_q  <= B1;
                     end
                     HIGH: begin
                        state_q <= LOW;
                        pout_q  <= B0;
                     end
                     default: begin
                        idx_q <= idx_d;
                        if (last_pulse) begin
                           state_q <= IDLE;
                           busy_q  <= 1'b0;
                           done_q  <= 1'b1;
                        end else begin
                           state_q <= HIGH;
                           pout_q  <= B1;
                        end
                     end
                  endcase
               end
            end
            default: begin
               state_q <= IDLE;
               pout_q  <= B0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pout      = pout_q;
   assign bus.sink_sel  = sink_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.cfg_err   = err_q;
   assign bus.pulse_idx = idx_q;
endmodule

// File: tb/tb_ipulse_seq.sv
// Directed bench for ipulse_seq: legality table plus hand-timed train sequences.
module tb_ipulse_seq;
   logic clk  = 1'b0;
   logic rstb = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   ipulse_seq_if #(.CNT_W(16), .NUM_W(8)) bus ();

   ipulse_seq #(.CNT_W(16), .NUM_W(8), .B0(1'b0), .B1(1'b1)) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus)
   );

   typedef struct {
      logic [15:0] td;
      logic [15:0] tw;
      logic [15:0] tp;
      logic        err;
      logic        busy;
      logic        pout;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int td, input int tw, input int tp, input int num, input logic sink);
      bus.cfg_td   = 16'(td);
      bus.cfg_tw   = 16'(tw);
      bus.cfg_tp   = 16'(tp);
      bus.cfg_num  = 8'(num);
      bus.cfg_sink = sink;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pout"},  32'(bus.pout), 0);
      chk({tag, "_sink"},  32'(bus.sink_sel), 0);
      chk({tag, "_busy"},  32'(bus.busy), 0);
      chk({tag, "_done"},  32'(bus.done), 0);
      chk({tag, "_err"},   32'(bus.cfg_err), 0);
      chk({tag, "_idx"},   32'(bus.pulse_idx), 0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      set_cfg(0, 1, 2, 0, 1'b0);

      tbl[0] = '{td: 16'd0, tw: 16'd4, tp: 16'd4, err: 1'b1, busy: 1'b0, pout: 1'b0};
      tbl[1] = '{td: 16'd0, tw: 16'd0, tp: 16'd5, err: 1'b1, busy: 1'b0, pout: 1'b0};
      tbl[2] = '{td: 16'd0, tw: 16'd3, tp: 16'd2, err: 1'b1, busy: 1'b0, pout: 1'b0};
      tbl[3] = '{td: 16'd0, tw: 16'd1, tp: 16'd2, err: 1'b0, busy: 1'b1, pout: 1'b1};
      tbl[4] = '{td: 16'd2, tw: 16'd2, tp: 16'd5, err: 1'b0, busy: 1'b1, pout: 1'b0};
      tbl[5] = '{td: 16'd0, tw: 16'd5, tp: 16'd6, err: 1'b0, busy: 1'b1, pout: 1'b1};

      repeat (2) tick();
      chk_reset_vals("rst");
      rstb = 1'b1;
      tick();

      // td=3 tw=2 tp=5 num=2: high on [3,5) and [8,10), done at 13
      set_cfg(3, 2, 5, 2, 1'b0);
      bus.start = 1'b1;
      for (int e = 0; e <= 14; e++) begin
         tick();
         bus.start = 1'b0;
         chk($sformatf("t1_pout_e%0d", e), 32'(bus.pout),
             32'(((e >= 3 && e < 5) || (e >= 8 && e < 10)) ? 1 : 0));
         chk($sformatf("t1_busy_e%0d", e), 32'(bus.busy), 32'((e < 13) ? 1 : 0));
         chk($sformatf("t1_done_e%0d", e), 32'(bus.done), 32'((e == 13) ? 1 : 0));
         chk($sformatf("t1_idx_e%0d", e), 32'(bus.pulse_idx),
             32'((e >= 13) ? 2 : (e >= 8) ? 1 : 0));
      end

      // continuous td=0 tw=1 tp=2: toggles each cycle, index wraps at edge 512
      set_cfg(0, 1, 2, 0, 1'b0);
      bus.start = 1'b1;
      for (int e = 0; e <= 600; e++) begin
         tick();
         bus.start = 1'b0;
         chk($sformatf("t2_pout_e%0d", e), 32'(bus.pout), 32'((e % 2 == 0) ? 1 : 0));
         chk($sformatf("t2_idx_e%0d", e), 32'(bus.pulse_idx), 32'((e / 2) % 256));
         chk($sformatf("t2_done_e%0d", e), 32'(bus.done), 0);
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("t2_abort_pout", 32'(bus.pout), 0);
      chk("t2_abort_busy", 32'(bus.busy), 0);
      chk("t2_abort_done", 32'(bus.done), 0);
      chk("t2_abort_idx", 32'(bus.pulse_idx), 44);
      tick();
      chk("t2_after_done", 32'(bus.done), 0);

      // legality table: one start per vector from IDLE
      for (int i = 0; i < 6; i++) begin
         set_cfg(int'(tbl[i].td), int'(tbl[i].tw), int'(tbl[i].tp), 1, 1'b0);
         bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
         chk($sformatf("tbl%0d_err", i), 32'(bus.cfg_err), 32'(tbl[i].err));
         chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
         chk($sformatf("tbl%0d_pout", i), 32'(bus.pout), 32'(tbl[i].pout));
         if (tbl[i].busy)
            bus.abort = 1'b1;
         tick();
         bus.abort = 1'b0;
         chk($sformatf("tbl%0d_err_clr", i), 32'(bus.cfg_err), 0);
         chk($sformatf("tbl%0d_idle", i), 32'(bus.busy), 0);
      end

      // sink train aborted mid-HIGH keeps polarity; next start relatches it
      set_cfg(0, 3, 6, 0, 1'b1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("t4_sink_acc", 32'(bus.sink_sel), 1);
      chk("t4_pout_acc", 32'(bus.pout), 1);
      tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("t4_abort_pout", 32'(bus.pout), 0);
      chk("t4_abort_busy", 32'(bus.busy), 0);
      chk("t4_abort_sink", 32'(bus.sink_sel), 1);
      chk("t4_abort_done", 32'(bus.done), 0);
      set_cfg(0, 1, 2, 0, 1'b0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("t4_sink_new", 32'(bus.sink_sel), 0);
      chk("t4_busy_new", 32'(bus.busy), 1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;

      // asynchronous reset during LOW of pulse 1
      set_cfg(0, 2, 5, 0, 1'b1);
      bus.start = 1'b1;
      for (int e = 0; e <= 8; e++) begin
         tick();
         bus.start = 1'b0;
      end
      chk("t5_pre_idx", 32'(bus.pulse_idx), 1);
      chk("t5_pre_sink", 32'(bus.sink_sel), 1);
      chk("t5_pre_busy", 32'(bus.busy), 1);
      #2 rstb = 1'b0;
      #1;
      chk_reset_vals("t5_async");
      tick();
      rstb = 1'b1;
      set_cfg(0, 2, 4, 1, 1'b0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("t5_restart_pout", 32'(bus.pout), 1);
      chk("t5_restart_busy", 32'(bus.busy), 1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;

      // start pulsed during HIGH with other cfg: timing follows original
      set_cfg(1, 2, 4, 2, 1'b1);
      bus.start = 1'b1;
      for (int e = 0; e <= 10; e++) begin
         tick();
         chk($sformatf("t6_pout_e%0d", e), 32'(bus.pout),
             32'(((e >= 1 && e < 3) || (e >= 5 && e < 7)) ? 1 : 0));
         chk($sformatf("t6_done_e%0d", e), 32'(bus.done), 32'((e == 9) ? 1 : 0));
         chk($sformatf("t6_busy_e%0d", e), 32'(bus.busy), 32'((e < 9) ? 1 : 0));
         chk($sformatf("t6_err_e%0d", e), 32'(bus.cfg_err), 0);
         chk($sformatf("t6_sink_e%0d", e), 32'(bus.sink_sel), 1);
         if (e == 0) begin
            bus.start = 1'b0;
            set_cfg(0, 1, 9, 0, 1'b0);
         end
         bus.start = (e == 1);
      end
      bus.start = 1'b0;

      // start and abort together in IDLE: no train
      set_cfg(0, 1, 2, 0, 1'b0);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("t7_busy", 32'(bus.busy), 0);
      chk("t7_pout", 32'(bus.pout), 0);
      chk("t7_err", 32'(bus.cfg_err), 0);

      // abort on the last LOW cycle of a finite train suppresses done
      set_cfg(0, 1, 3, 1, 1'b0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("t8_done", 32'(bus.done), 0);
      chk("t8_busy", 32'(bus.busy), 0);
      chk("t8_idx", 32'(bus.pulse_idx), 0);
      tick();
      chk("t8_done_late", 32'(bus.done), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ipulse_seq.md
Name: ipulse_seq

Overview:
- Clocked digital sequencer for a current-pulse stimulus source. Generates the bit-level pulse train (pout) and the source/sink select that drive a bit2pwl-based current pulse output stage.
- Replaces fixed td/tw/tp parameters with run-time configuration, start/abort control and a finite pulse count.
- Sits between testbench/control logic and the current-pulse output stage.

Parameters:
- CNT_W, 16, width of the delay/width/period cycle counters.
- NUM_W, 8, width of the pulse-count field.
- B0, 1'b0, pout level when idle or low.
- B1, 1'b1, pout level during the pulse high phase.

Ports:
- clk  input  1  sequencer clock; all state updates on rising edge.
- rstb  input  1  asynchronous active-low reset.
- start  input  1  request a pulse train; sampled only in IDLE.
- abort  input  1  terminate the current train.
- cfg_td  input  CNT_W  initial delay, in clk cycles.
- cfg_tw  input  CNT_W  pulse width, in clk cycles.
- cfg_tp  input  CNT_W  pulse period, in clk cycles.
- cfg_num  input  NUM_W  number of pulses; 0 = continuous until abort.
- cfg_sink  input  1  1 = sink current, 0 = source current.
- pout  output  1  pulse bit to the output stage.
- sink_sel  output  1  latched cfg_sink, held for the whole train.
- busy  output  1  high in any non-IDLE state.
- done  output  1  one-cycle pulse when a finite train completes.
- cfg_err  output  1  one-cycle pulse when a start is rejected.
- pulse_idx  output  NUM_W  index of the current pulse (0-based).

Behaviour:
- Reset (rstb low, asynchronous):
  - state = IDLE; pout = B0; sink_sel = 0; busy = 0; done = 0; cfg_err = 0; pulse_idx = 0; all counters = 0.
- States: IDLE, DELAY, HIGH, LOW.
- All outputs are registered.
- Legality check on start in IDLE:
  - Illegal if cfg_tw == 0, or cfg_tp <= cfg_tw.
  - Illegal start: cfg_err = 1 for one cycle; state stays IDLE; no other output changes.
- Legal start accepted at edge k:
  - Latch td/tw/tp/num/sink; sink_sel updates at edge k.
  - If td == 0: go to HIGH at edge k; pout = B1 after edge k.
  - If td > 0: go to DELAY at edge k; pout = B1 after edge k+td.
- Phase lengths:
  - pout remains B1 for exactly tw cycles.
  - pout then remains B0 for exactly tp-tw cycles (LOW).
  - Rising edges of pout are spaced exactly tp cycles apart.
- End of each LOW phase:
  - pulse_idx increments.
  - If cfg_num != 0 and the incremented value == num: go to IDLE; done = 1 for that one cycle; busy falls on the same edge.
  - Otherwise go to HIGH.
- pulse_idx:
  - Holds its final value in IDLE.
  - Clears on the next accepted start.
- Continuous mode (num == 0): pulse_idx wraps modulo 2^NUM_W; no done.
- Counters: down-counters loaded with (length-1). Widths are exactly CNT_W; there is no overflow because tp < 2^CNT_W by construction.
- Abort (abort sampled high in DELAY/HIGH/LOW):
  - Next edge: state = IDLE; pout = B0.
  - done not asserted; pulse_idx keeps its value.
  - sink_sel holds its value, so the output stage does not glitch polarity.
- start while busy: ignored; no cfg_err.
- start and abort in the same IDLE cycle: abort wins; start ignored.
- abort on the last LOW cycle of a finite train: abort wins; no done.
- cfg_* inputs changing while busy: no effect until the next start.
- Reset mid-train: immediate return to reset values; no done.

Decomposition:
- Shared package ipulse_pkg holds:
  - state enum (IDLE, DELAY, HIGH, LOW);
  - default CNT_W/NUM_W localparams;
  - legality-check function (tw, tp) -> ok.
- One natural sub-module: ipulse_timer. It is a loadable CNT_W down-counter with load/enable inputs and a zero flag. One instance is reused for all three phases.
- Top level: FSM plus config latches; optionally instantiates the existing bit2pwl stage in a wrapper (not part of this block).

Test Plan:
- td=3, tw=2, tp=5, num=2, start at edge 0:
  - pout high on edges [3,5) and [8,10);
  - done at edge 13; busy low from edge 13;
  - pulse_idx = 2.
- td=0, tw=1, tp=2, num=0:
  - pout toggles every cycle starting edge 0;
  - pulse_idx wraps 255 -> 0;
  - abort at edge 600 -> pout = 0 and IDLE at edge 601; no done.
- tw=4, tp=4 -> cfg_err one cycle, busy stays 0. tw=0 -> cfg_err one cycle, busy stays 0.
- cfg_sink=1 train with abort mid-HIGH -> sink_sel stays 1 after abort; pout = 0 next edge. A new start with cfg_sink=0 -> sink_sel = 0 at the accept edge.
- rstb low mid-LOW of pulse 1 -> all outputs reset asynchronously (before the next clk edge). After release, a start with td=0 gives pout high at the accept edge.
- start pulsed during HIGH with different cfg -> ignored; timing matches the original config exactly. start+abort together in IDLE -> no train.
